// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: word load/store over req/ready, write-back select, MEM/WB register
// A stalled access keeps EX/MEM held upstream, so the request fields stay stable while in S_WAIT.
module mem_stage #(
   parameter int WAIT_LIMIT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_mem_MemWr_out,
   input  logic        ex_mem_MemRead_out,
   input  logic [1:0]  ex_mem_MemToReg_out,
   input  logic        ex_mem_RegWrite_out,
   input  logic [31:0] ex_mem_pc_plus_4_out,
   input  logic [31:0] ex_mem_ALUOut_out,
   input  logic [31:0] ex_mem_DataBus2_out,
   input  logic [4:0]  ex_mem_RegWriteAddr_out,
   input  logic [1:0]  regOption,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ready,
   output logic        mem_stall,
   output logic        mem_fault,
   output logic        mem_wb_RegWrite_out,
   output logic [4:0]  mem_wb_RegWriteAddr_out,
   output logic [31:0] mem_wb_RegWriteData_out
);

   localparam int CW = $clog2(WAIT_LIMIT + 1);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t        state;
   logic [CW-1:0] wait_cnt;

   logic        mem_op;
   logic        aligned;
   logic        access;
   logic        misaligned;
   logic        abort;
   logic        bubble;
   logic [31:0] wb_data;

   assign mem_op     = ex_mem_MemRead_out | ex_mem_MemWr_out;
   assign aligned    = (ex_mem_ALUOut_out[1:0] == 2'b00);
   assign access     = mem_op & rst_n & aligned;
   assign misaligned = mem_op & ~aligned;

   // Abort fires in the cycle the counter hits its last value with no ready,
   // which caps the stall at WAIT_LIMIT cycles including the initial IDLE cycle.
   assign abort = (state == S_WAIT) & ~dmem_ready & (wait_cnt == CW'(WAIT_LIMIT - 1));

   assign dmem_req   = (state == S_WAIT) ? (rst_n & ~abort) : access;
   assign dmem_we    = ex_mem_MemWr_out;
   assign dmem_addr  = {ex_mem_ALUOut_out[31:2], 2'b00};
   assign dmem_wdata = ex_mem_DataBus2_out;
   assign mem_stall  = access & ~dmem_ready & ~abort;
   assign bubble     = mem_stall | misaligned | abort;

   always_comb begin
      wb_data = ex_mem_ALUOut_out;
      case (ex_mem_MemToReg_out)
         2'b01:   wb_data = ex_mem_MemWr_out ? ex_mem_ALUOut_out : dmem_rdata;
         2'b10:   wb_data = ex_mem_pc_plus_4_out;
         default: wb_data = ex_mem_ALUOut_out;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state                   <= S_IDLE;
         wait_cnt                <= '0;
         mem_fault               <= 1'b0;
         mem_wb_RegWrite_out     <= 1'b0;
         mem_wb_RegWriteAddr_out <= '0;
         mem_wb_RegWriteData_out <= '0;
      end else begin
         mem_fault <= misaligned | abort;

         case (state)
            S_IDLE: begin
               if (access && !dmem_ready) begin
                  state    <= S_WAIT;
                  wait_cnt <= '0;
               end
            end
            S_WAIT: begin
               if (dmem_ready || abort) begin
                  state <= S_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase

         if (bubble) begin
            mem_wb_RegWrite_out     <= 1'b0;
            mem_wb_RegWriteAddr_out <= '0;
            mem_wb_RegWriteData_out <= '0;
         end else begin
            case (regOption)
               2'b00: begin
                  mem_wb_RegWrite_out     <= ex_mem_RegWrite_out;
                  mem_wb_RegWriteAddr_out <= ex_mem_RegWriteAddr_out;
                  mem_wb_RegWriteData_out <= wb_data;
               end
               2'b01: begin
                  mem_wb_RegWrite_out     <= 1'b0;
                  mem_wb_RegWriteAddr_out <= ex_mem_RegWriteAddr_out;
                  mem_wb_RegWriteData_out <= wb_data;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage pipeline: consumes the EX/MEM pipeline register outputs, performs word loads and stores against a variable-latency data memory through a req/ready handshake, selects the write-back value and drives the MEM/WB pipeline register. While an access is outstanding it raises a stall to the hazard unit. The registered MEM/WB write-back data is also the forwarding source returned to the execute stage.

## Interface
Parameters:
- `WAIT_LIMIT`, default 255: maximum number of stall cycles per access before timeout.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `ex_mem_MemWr_out` in 1: store request from the EX/MEM register.
- `ex_mem_MemRead_out` in 1: load request.
- `ex_mem_MemToReg_out` in 2: write-back source select.
- `ex_mem_RegWrite_out` in 1: register write enable.
- `ex_mem_pc_plus_4_out` in 32: PC+4 of the instruction.
- `ex_mem_ALUOut_out` in 32: ALU result; also the memory byte address.
- `ex_mem_DataBus2_out` in 32: store data.
- `ex_mem_RegWriteAddr_out` in 5: destination register.
- `regOption` in 2: MEM/WB register control from the hazard unit.
  - 00: update.
  - 01: bubble.
  - 10 or 11: hold.
- `dmem_req` out 1: access request.
- `dmem_we` out 1: 1 = write, 0 = read.
- `dmem_addr` out 32: word-aligned address, equal to {ALUOut[31:2], 2'b00}.
- `dmem_wdata` out 32: store data.
- `dmem_rdata` in 32: read data, valid when `dmem_ready` is 1.
- `dmem_ready` in 1: access completes this cycle.
- `mem_stall` out 1: pipeline stall request (combinational).
- `mem_fault` out 1: registered one-cycle pulse on a misaligned access or a timeout.
- `mem_wb_RegWrite_out` out 1: MEM/WB register write enable.
- `mem_wb_RegWriteAddr_out` out 5: MEM/WB destination register.
- `mem_wb_RegWriteData_out` out 32: MEM/WB write-back data; this is also the forwarding source.

## Operation
- `access` = (MemRead | MemWr) & rst_n & (ALUOut[1:0] == 0).
- `misaligned` = (MemRead | MemWr) & (ALUOut[1:0] != 0). A misaligned access:
  - issues no request;
  - forces a bubble into MEM/WB;
  - pulses `mem_fault` on the next cycle;
  - causes no stall.
- If MemRead and MemWr are both 1, the access is a write (`dmem_we` = 1) and no load data is used.
- FSM states:
  - IDLE:
    - `dmem_req` = `access`.
    - If `access` and `dmem_ready`: complete in this cycle, no stall.
    - If `access` and not `dmem_ready`: go to WAIT and clear the wait counter.
  - WAIT:
    - `dmem_req` = 1; `dmem_we`, `dmem_addr` and `dmem_wdata` stay stable (upstream holds EX/MEM while stalled).
    - Counter increments each cycle.
    - If `dmem_ready`: complete and return to IDLE.
    - If the counter reaches `WAIT_LIMIT` without `dmem_ready`: abort, drop `dmem_req`, bubble MEM/WB, pulse `mem_fault`, return to IDLE.
- `mem_stall` = `access` & ~`dmem_ready` & ~`abort` (valid in either state). It is 0 during reset.
- Write-back select:
  - MemToReg 00 or 11: ALUOut.
  - MemToReg 01: `dmem_rdata` sampled in the completing cycle.
  - MemToReg 10: pc_plus_4.
- MEM/WB update priority, highest first:
  1. reset: all outputs cleared;
  2. `mem_stall`, misaligned or abort: bubble (RegWrite 0, address and data cleared);
  3. `regOption`.
- Bubble clears only the control bit (`mem_wb_RegWrite_out`) when `regOption` = 01. The address and data fields are loaded normally in that case.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - All `mem_wb_*` outputs 0; `mem_fault` 0.
  - `dmem_req` and `mem_stall` are 0 while `rst_n` = 0.
- A reset asserted in WAIT abandons the access. `dmem_req` drops in the same cycle because it is gated by `rst_n`.
- Zero-wait access: MEM/WB is loaded at the edge ending the request cycle, giving 1-cycle latency, identical to a non-memory instruction.
- N wait cycles: `mem_stall` is high for N cycles and MEM/WB loads at the edge of the `dmem_ready` cycle.
- The hazard unit stalls all earlier stages for that duration.
- `mem_stall` falls in the `dmem_ready` cycle, so the upstream stages advance on that same edge.
- A back-to-back access in the next cycle starts in IDLE with no dead cycle.

## Test plan
- ALU op: RegWrite 1, MemToReg 00, ALUOut 0x1234, dest 5, `regOption` 00 → next cycle `mem_wb` = {1, 5, 0x1234}; `dmem_req` stays 0.
- Zero-wait load: address 0x10, `dmem_ready` held 1, rdata 0xDEADBEEF, MemToReg 01 → `mem_stall` is never 1; next cycle data = 0xDEADBEEF.
- Load with 3 wait cycles:
  - `mem_stall` is 1 for exactly 3 cycles, with `dmem_addr` stable at 0x10;
  - MEM/WB RegWrite stays 0 until the edge of the ready cycle, after which data = rdata.
- Store to 0x22 (misaligned) → `dmem_req` 0, `mem_stall` 0, `mem_fault` pulses once, MEM/WB RegWrite 0.
- Timeout with `WAIT_LIMIT` = 4 and `dmem_ready` held 0 → stall ends after 4 cycles, `mem_fault` pulses, bubble in MEM/WB, FSM back in IDLE.
- Reset mid-WAIT: `rst_n` goes low on the 2nd wait cycle → `dmem_req` 0 immediately; after release all `mem_wb` outputs are 0 and the state is IDLE.
- Call with MemToReg 10 and pc_plus_4 = 0x400 → data 0x400, dest 31; with `regOption` 10 in the following cycle the MEM/WB outputs hold.
